// File: rtl/kernel_pr_start_pkg.sv
// rtl/kernel_pr_start_pkg.sv - shared types and limits for the start-token writer
package kernel_pr_start_pkg;

    localparam int MAX_NUM_OUT            = 16;
    localparam int DEFAULT_NUM_OUT        = 2;
    localparam int DEFAULT_CNT_WIDTH      = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/kernel_pr_start_token_slot.sv
// rtl/kernel_pr_start_token_slot.sv - one pending start token for a single downstream FIFO
module kernel_pr_start_token_slot
    import kernel_pr_start_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic arm,
    input  logic issue,
    input  logic full_n,
    output logic write,
    output logic blocked
);

    logic pend;

    // The token is written the first cycle its FIFO has room, then never again this iteration.
    assign write   = issue & pend & full_n;
    assign blocked = issue & pend & ~full_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= 1'b0;
        end else if (arm) begin
            pend <= 1'b1;
        end else if (write) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/kernel_pr_start_token_writer.sv
// rtl/kernel_pr_start_token_writer.sv - launches a producer iteration and writes one start token per FIFO; KERNEL_PR_START_TIMEOUT_EN adds a sticky stall flag
module kernel_pr_start_token_writer
    import kernel_pr_start_pkg::*;
#(
    parameter int NUM_OUT        = DEFAULT_NUM_OUT,
    parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ap_start,
    output logic                 ap_ready,
    output logic                 core_start,
    input  logic                 core_ready,
    input  logic [NUM_OUT-1:0]   start_full_n,
    output logic [NUM_OUT-1:0]   start_write,
    output logic [CNT_WIDTH-1:0] iter_count,
    output logic                 idle,
    output logic                 stall_err
);

    if (NUM_OUT < 1 || NUM_OUT > MAX_NUM_OUT) begin : g_bad_num_out
        $error("kernel_pr_start_token_writer: NUM_OUT out of range");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("kernel_pr_start_token_writer: TIMEOUT_CYCLES must be positive");
    end

    state_t             state;
    logic               core_acc;
    logic               issue;
    logic               arm;
    logic               done;
    logic [NUM_OUT-1:0] blocked;

    assign issue      = (state == ST_ISSUE);
    assign arm        = (state == ST_IDLE) & ap_start;
    assign idle       = ~issue;
    assign core_start = issue & ~core_acc;

    // Completion needs no token stuck behind a full FIFO and the core either taken or taking now.
    assign done     = issue & ~(|blocked) & (core_acc | core_ready);
    assign ap_ready = done;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
        kernel_pr_start_token_slot u_slot (
            .clk     (clk),
            .reset   (reset),
            .arm     (arm),
            .issue   (issue),
            .full_n  (start_full_n[i]),
            .write   (start_write[i]),
            .blocked (blocked[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (ap_start) state <= ST_ISSUE;
                ST_ISSUE: if (done)     state <= ST_IDLE;
                default:                state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_acc <= 1'b0;
        end else if (arm) begin
            core_acc <= 1'b0;
        end else if (core_start & core_ready) begin
            core_acc <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iter_count <= '0;
        end else if (done) begin
            iter_count <= iter_count + 1'b1;
        end
    end

`ifdef KERNEL_PR_START_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] stall_cnt;
    logic          stall_flag;

    // Counts ISSUE cycles of the current iteration; the flag survives until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            stall_flag <= 1'b0;
        end else if (arm) begin
            stall_cnt <= '0;
        end else if (issue) begin
            if (stall_cnt == TO_LAST) begin
                stall_flag <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign stall_err = stall_flag;
`else
    assign stall_err = 1'b0;
`endif

endmodule
